// File: rtl/spi_byte_engine_pkg.sv
// Shared SPI definitions: FSM encodings, idle line level and default divider settings.
package spi_byte_engine_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } spi_state_t;

    localparam logic MOSI_IDLE = 1'b1;

    // Half-period settings assuming a 50 MHz clk: ~397 kHz for SD init, clk/2 when fast.
    localparam logic [7:0] DIV_SD_INIT = 8'd62;
    localparam logic [7:0] DIV_FAST    = 8'd0;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period down-counter: load latches the period, then it reloads itself at terminal count.
module spi_clk_div #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             tc
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] period;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            period <= '0;
        end else if (load) begin
            cnt    <= load_val;
            period <= load_val;
        end else if (en) begin
            if (cnt == '0) cnt <= period;
            else           cnt <= cnt - 1'b1;
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/spi_byte_engine.sv
// Mode-0 SPI master byte shifter with a one-entry transmit holding register.
// state   | meaning
// IDLE    | sclk low, mosi high, waiting for a held byte
// LOW     | sclk low half of the current bit
// HIGH    | sclk high half of the current bit
module spi_byte_engine
    import spi_byte_engine_pkg::*;
#(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 _reset,
    input  logic [DIV_WIDTH-1:0] clk_div,
    input  logic [7:0]           tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [7:0]           rx_data,
    output logic                 rx_valid,
    output logic                 busy,
    input  logic                 abort,
    input  logic                 miso,
    output logic                 mosi,
    output logic                 sclk
);

    spi_state_t state, state_nx;
    logic       hold_full;
    logic [7:0] hold_data;
    logic [7:0] shifter;
    logic [2:0] bit_idx;
    logic       tc, rise, fall, last, load_byte, accept;
    logic       sclk_nx, mosi_nx;

    spi_clk_div #(.WIDTH(DIV_WIDTH)) u_clk_div (
        .clk      (clk),
        .rst_n    (_reset),
        .load     (load_byte),
        .load_val (clk_div),
        .en       (state != ST_IDLE),
        .tc       (tc)
    );

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) state <= ST_IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (abort) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (hold_full) state_nx = ST_LOW;
                ST_LOW:  if (tc) state_nx = ST_HIGH;
                ST_HIGH: if (tc) state_nx = (bit_idx != 3'd7 || hold_full) ? ST_LOW : ST_IDLE;
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rise      = !abort && (state == ST_LOW) && tc;
        fall      = !abort && (state == ST_HIGH) && tc;
        last      = fall && (bit_idx == 3'd7);
        // A byte waiting at the end of the last bit loads immediately, so sclk never pauses.
        load_byte = !abort && hold_full && ((state == ST_IDLE) || last);
        accept    = !abort && tx_valid && !hold_full;

        sclk_nx = sclk;
        if (abort)     sclk_nx = 1'b0;
        else if (rise) sclk_nx = 1'b1;
        else if (fall) sclk_nx = 1'b0;

        mosi_nx = mosi;
        if (abort)          mosi_nx = MOSI_IDLE;
        else if (load_byte) mosi_nx = hold_data[7];
        else if (last)      mosi_nx = MOSI_IDLE;
        else if (fall)      mosi_nx = shifter[7];
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            sclk      <= 1'b0;
            mosi      <= MOSI_IDLE;
            hold_full <= 1'b0;
            hold_data <= 8'h00;
            shifter   <= 8'h00;
            bit_idx   <= 3'd0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
        end else begin
            sclk     <= sclk_nx;
            mosi     <= mosi_nx;
            rx_valid <= last;
            if (last) rx_data <= shifter;

            if (abort || load_byte) hold_full <= 1'b0;
            else if (accept)        hold_full <= 1'b1;
            if (accept) hold_data <= tx_data;

            // One register shifts out MSB first while miso fills in from the LSB side.
            if (load_byte) begin
                shifter <= hold_data;
                bit_idx <= 3'd0;
            end else begin
                if (rise)          shifter <= {shifter[6:0], miso};
                if (fall && !last) bit_idx <= bit_idx + 3'd1;
            end
        end
    end

    assign tx_ready = !hold_full;
    assign busy     = (state != ST_IDLE) || hold_full;

endmodule

// File: tb/tb_spi_byte_engine.sv
// Directed bench for spi_byte_engine: vector table of single bytes plus multi-byte corner sequences.
module tb_spi_byte_engine;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] clk_div;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       abort;
    logic       miso;
    logic       mosi;
    logic       sclk;

    logic       loop;
    logic [7:0] slave_sh;
    logic [7:0] mosi_cap;
    int         cyc = 0;
    int         rise_q[$];
    int         rxc_q[$];
    logic [7:0] rx_q[$];
    int         checks = 0;
    int         passes = 0;

    typedef struct {
        logic [7:0] tx;
        logic [7:0] div;
        logic       lp;
        logic [7:0] slave;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vecs[6];

    spi_byte_engine #(.DIV_WIDTH(8)) dut (
        .clk      (clk),
        ._reset   (rst_n),
        .clk_div  (clk_div),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .busy     (busy),
        .abort    (abort),
        .miso     (miso),
        .mosi     (mosi),
        .sclk     (sclk)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Slave model: presents MSB before the first rise and shifts on each sclk fall.
    assign miso = loop ? mosi : slave_sh[7];
    always @(negedge sclk) slave_sh = {slave_sh[6:0], 1'b0};

    always @(posedge sclk) begin
        mosi_cap = {mosi_cap[6:0], mosi};
        rise_q.push_back(cyc);
    end

    always @(negedge clk) begin
        if (rx_valid) begin
            rx_q.push_back(rx_data);
            rxc_q.push_back(cyc);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        rise_q.delete();
        rx_q.delete();
        rxc_q.delete();
        mosi_cap = 8'h00;
    endtask

    task automatic send(input logic [7:0] b, output int acc);
        int k = 0;
        while (!tx_ready && k < 2000) begin
            tick();
            k++;
        end
        if (!tx_ready) chk("tx_ready_wait", int'(tx_ready), 1);
        tx_data  = b;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        acc      = cyc;
    endtask

    task automatic wait_rx(input int n);
        int k = 0;
        while (rx_q.size() < n && k < 3000) begin
            tick();
            k++;
        end
        if (rx_q.size() < n) chk("rx_wait", rx_q.size(), n);
    endtask

    task automatic chk_rises(input int from, input int to, input int per);
        for (int i = from; i <= to; i++)
            if (i < rise_q.size()) chk("sclk_half_spacing", rise_q[i] - rise_q[i-1], per);
    endtask

    task automatic run_single(input logic [7:0] b, input logic [7:0] d, input logic lp,
                              input logic [7:0] sl, input logic [7:0] exp_rx);
        int acc;
        clk_div  = d;
        loop     = lp;
        slave_sh = sl;
        clear_mon();
        send(b, acc);
        wait_rx(1);
        if (rx_q.size() >= 1) begin
            chk("rx_data", int'(rx_q[0]), int'(exp_rx));
            chk("byte_latency", rxc_q[0] - acc, 16 * (int'(d) + 1) + 1);
        end
        tick();
        chk("rx_valid_pulse", int'(rx_valid), 0);
        chk("idle_sclk", int'(sclk), 0);
        chk("idle_mosi", int'(mosi), 1);
        chk("idle_busy", int'(busy), 0);
        chk("mosi_bits", int'(mosi_cap), int'(b));
        chk("rise_count", rise_q.size(), 8);
        chk_rises(1, 7, 2 * (int'(d) + 1));
    endtask

    initial begin
        int a, b2, k;
        logic [7:0] rb, rd;

        vecs[0] = '{tx: 8'hA5, div: 8'd1, lp: 1'b0, slave: 8'h3C, exp_rx: 8'h3C};
        vecs[1] = '{tx: 8'hFF, div: 8'd0, lp: 1'b0, slave: 8'h00, exp_rx: 8'h00};
        vecs[2] = '{tx: 8'h00, div: 8'd2, lp: 1'b0, slave: 8'hFF, exp_rx: 8'hFF};
        vecs[3] = '{tx: 8'h81, div: 8'd7, lp: 1'b0, slave: 8'h7E, exp_rx: 8'h7E};
        vecs[4] = '{tx: 8'h5A, div: 8'd0, lp: 1'b1, slave: 8'h00, exp_rx: 8'h5A};
        vecs[5] = '{tx: 8'hC3, div: 8'd3, lp: 1'b0, slave: 8'h96, exp_rx: 8'h96};

        rst_n    = 1'b0;
        clk_div  = 8'd1;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        abort    = 1'b0;
        loop     = 1'b0;
        slave_sh = 8'h00;
        mosi_cap = 8'h00;
        tick();
        tick();
        chk("rst_sclk", int'(sclk), 0);
        chk("rst_mosi", int'(mosi), 1);
        chk("rst_rx_data", int'(rx_data), 0);
        chk("rst_rx_valid", int'(rx_valid), 0);
        chk("rst_tx_ready", int'(tx_ready), 1);
        chk("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++)
            run_single(vecs[i].tx, vecs[i].div, vecs[i].lp, vecs[i].slave, vecs[i].exp_rx);

        // Back-to-back at clk/2: second byte queued while the first shifts.
        clk_div = 8'd0;
        loop    = 1'b1;
        clear_mon();
        send(8'hFF, a);
        send(8'h00, b2);
        chk("b2b_tx_ready_full", int'(tx_ready), 0);
        chk("b2b_busy_full", int'(busy), 1);
        wait_rx(2);
        if (rx_q.size() >= 2) begin
            chk("b2b_rx0", int'(rx_q[0]), 8'hFF);
            chk("b2b_rx1", int'(rx_q[1]), 8'h00);
            chk("b2b_rx_spacing", rxc_q[1] - rxc_q[0], 16);
        end
        tick();
        chk("b2b_rx_count", rx_q.size(), 2);
        chk("b2b_rise_count", rise_q.size(), 16);
        chk_rises(1, 15, 2);

        // Divider change mid-byte only affects the next byte.
        clk_div = 8'd1;
        clear_mon();
        send(8'h3C, a);
        tick();
        tick();
        tick();
        clk_div = 8'd3;
        send(8'hC5, b2);
        wait_rx(2);
        if (rx_q.size() >= 2) begin
            chk("div_rx0", int'(rx_q[0]), 8'h3C);
            chk("div_rx1", int'(rx_q[1]), 8'hC5);
            chk("div_rx_spacing", rxc_q[1] - rxc_q[0], 64);
        end
        chk_rises(1, 7, 4);
        chk_rises(9, 15, 8);
        tick();

        // Abort during bit 4 with a byte pending.
        clk_div = 8'd1;
        clear_mon();
        send(8'h96, a);
        send(8'h11, b2);
        k = 0;
        while (rise_q.size() < 5 && k < 500) begin
            tick();
            k++;
        end
        chk("abort_reach_bit4", rise_q.size(), 5);
        abort    = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'hEE;
        tick();
        abort    = 1'b0;
        tx_valid = 1'b0;
        chk("abort_sclk", int'(sclk), 0);
        chk("abort_mosi", int'(mosi), 1);
        chk("abort_busy", int'(busy), 0);
        chk("abort_tx_ready", int'(tx_ready), 1);
        for (int i = 0; i < 60; i++) tick();
        chk("abort_no_rx", rx_q.size(), 0);
        run_single(8'h3C, 8'd1, 1'b1, 8'h00, 8'h3C);

        // Async reset mid-transfer, then loopback.
        clk_div = 8'd2;
        clear_mon();
        send(8'hA7, a);
        for (int i = 0; i < 10; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_sclk", int'(sclk), 0);
        chk("arst_mosi", int'(mosi), 1);
        chk("arst_rx_data", int'(rx_data), 0);
        chk("arst_rx_valid", int'(rx_valid), 0);
        chk("arst_tx_ready", int'(tx_ready), 1);
        chk("arst_busy", int'(busy), 0);
        tick();
        rst_n = 1'b1;
        tick();
        run_single(8'h5A, 8'd1, 1'b1, 8'h00, 8'h5A);

        // Random divider, random gaps, loopback.
        for (int i = 0; i < 20; i++) begin
            rd = 8'($urandom_range(0, 7));
            rb = 8'($urandom_range(0, 255));
            k  = int'($urandom_range(0, 5));
            for (int g = 0; g < k; g++) tick();
            run_single(rb, rd, 1'b1, 8'h00, rb);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
